// File: rtl/usb_sniffer_wr_buffer_if.sv
// Bus bundle for the sniffer posted-write buffer.
// Carries the Wishbone request side (mem_*) and the RAM-bridge write side (ram_*).

interface usb_sniffer_wr_buffer_if;
  // Wishbone memory master -> buffer
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_sel;
  logic        mem_stb;
  logic        mem_we;
  logic        mem_stall;
  logic        mem_ack;

  // buffer -> SoC RAM bridge
  logic [29:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_data;
  logic        ram_write;
  logic        ram_ack;

  // slave is the buffer itself; master is the sniffer together with the bridge around it
  modport slave (
    input  mem_addr, mem_data, mem_sel, mem_stb, mem_we,
    output mem_stall, mem_ack,
    output ram_addr, ram_be, ram_data, ram_write,
    input  ram_ack
  );

  modport master (
    output mem_addr, mem_data, mem_sel, mem_stb, mem_we,
    input  mem_stall, mem_ack,
    input  ram_addr, ram_be, ram_data, ram_write,
    output ram_ack
  );
endinterface

// File: rtl/usb_sniffer_wr_buffer.sv
// Posted-write FIFO between the usb_sniffer Wishbone master and the SoC RAM bridge.
// Drains one entry at a time with a hold-until-ack handshake guarded by a response watchdog.

module usb_sniffer_wr_buffer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  usb_sniffer_wr_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      busy_o,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = 30 + 4 + 32;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ack_reg;

  state_t        state_reg;
  logic [TW-1:0] tmr_reg;
  logic          write_reg;
  logic          err_reg;
  logic [29:0]   addr_reg;
  logic [3:0]    be_reg;
  logic [31:0]   data_reg;

  logic full;
  logic accept;
  logic push;
  logic pop;
  logic unused_addr_lsbs;

  // Byte-lane offset is carried by the byte enables, not the word address.
  assign unused_addr_lsbs = ^bus.mem_addr[1:0];

  // Stall comes straight from the registered count, so a pop while full frees a slot one cycle later.
  assign full   = (count_reg == FULL_LEVEL);
  assign accept = bus.mem_stb && !full;
  assign push   = accept && bus.mem_we;
  assign pop    = (state_reg == IDLE) && (count_reg != '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.mem_addr[31:2], bus.mem_sel, bus.mem_data};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ack_reg    <= 1'b0;
    end else begin
      // Reads are acknowledged like writes but never reach the queue.
      ack_reg <= accept;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      tmr_reg   <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      be_reg    <= '0;
      data_reg  <= '0;
    end else begin
      // A timeout later in this block overrides the clear, so a fresh error is never lost.
      if (err_clr_i) begin
        err_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (pop) begin
            {addr_reg, be_reg, data_reg} <= fifo_mem[rd_ptr_reg];
            write_reg <= 1'b1;
            tmr_reg   <= '0;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          if (bus.ram_ack) begin
            write_reg <= 1'b0;
            state_reg <= GAP;
          end else if (tmr_reg == TMR_LAST) begin
            write_reg <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= GAP;
          end else begin
            tmr_reg <= tmr_reg + TW'(1);
          end
        end
        GAP: begin
          // One dead cycle lets the bridge re-arm before the next request.
          state_reg <= IDLE;
        end
        default: begin
          write_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_stall = full;
  assign bus.mem_ack   = ack_reg;
  assign bus.ram_addr  = addr_reg;
  assign bus.ram_be    = be_reg;
  assign bus.ram_data  = data_reg;
  assign bus.ram_write = write_reg;

  assign level_o = count_reg;
  assign busy_o  = (count_reg != '0) || (state_reg != IDLE);
  assign err_o   = err_reg;

endmodule

// File: tb/tb_usb_sniffer_wr_buffer.sv
// Directed bench for usb_sniffer_wr_buffer (DEPTH=16, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_usb_sniffer_wr_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic [4:0] level;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [29:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_be[$];

  usb_sniffer_wr_buffer_if bus();

  usb_sniffer_wr_buffer #(
    .DEPTH   (16),
    .TIMEOUT (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .level_o   (level),
    .busy_o    (busy),
    .err_o     (err),
    .err_clr_i (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.mem_stb  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_data = '0;
    bus.mem_sel  = '0;
  endtask

  task automatic put(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.mem_stb  = 1'b1;
    bus.mem_we   = we;
    bus.mem_addr = a;
    bus.mem_data = d;
    bus.mem_sel  = s;
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_be.delete();
  endtask

  // Bridge model: acknowledges a visible write in the same cycle and logs it.
  task automatic bridge_step(input logic en);
    bus.ram_ack = en && bus.ram_write;
    if (en && bus.ram_write) begin
      got_addr.push_back(bus.ram_addr);
      got_data.push_back(bus.ram_data);
      got_be.push_back(bus.ram_be);
      $display("  bridge write addr=0x%08h data=0x%08h be=0x%0h", bus.ram_addr, bus.ram_data, bus.ram_be);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      bridge_step(1'b1);
      n++;
    end while ((busy || bus.ram_write) && n < 300);
    bus.ram_ack = 1'b0;
    chk({tag, "_drained"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int wcount;
    logic ack_en;
    logic [31:0] j;

    rst_n       = 1'b0;
    err_clr     = 1'b0;
    bus.ram_ack = 1'b0;
    idle_bus();

    // ---- reset state ----
    cyc();
    cyc();
    chk("rst_stall", 64'(bus.mem_stall), 64'(0));
    chk("rst_ack",   64'(bus.mem_ack),   64'(0));
    chk("rst_write", 64'(bus.ram_write), 64'(0));
    chk("rst_addr",  64'(bus.ram_addr),  64'(0));
    chk("rst_be",    64'(bus.ram_be),    64'(0));
    chk("rst_data",  64'(bus.ram_data),  64'(0));
    chk("rst_level", 64'(level),         64'(0));
    chk("rst_busy",  64'(busy),          64'(0));
    chk("rst_err",   64'(err),           64'(0));
    rst_n = 1'b1;
    cyc();
    $display("reset released");

    // ---- single write, bridge acks in the 3rd write cycle ----
    cyc();
    put(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    chk("t1_stall", 64'(bus.mem_stall), 64'(0));
    cyc();
    idle_bus();
    chk("t1_ack_n1",   64'(bus.mem_ack),   64'(1));
    chk("t1_wr_n1",    64'(bus.ram_write), 64'(0));
    chk("t1_level_n1", 64'(level),         64'(1));
    cyc();
    chk("t1_ack_n2",   64'(bus.mem_ack),   64'(0));
    chk("t1_wr_n2",    64'(bus.ram_write), 64'(1));
    chk("t1_addr",     64'(bus.ram_addr),  64'(30'h40));
    chk("t1_data",     64'(bus.ram_data),  64'(32'hDEAD_BEEF));
    chk("t1_be",       64'(bus.ram_be),    64'(4'hF));
    chk("t1_level_n2", 64'(level),         64'(0));
    chk("t1_busy_n2",  64'(busy),          64'(1));
    cyc();
    chk("t1_wr_n3", 64'(bus.ram_write), 64'(1));
    cyc();
    chk("t1_wr_n4",   64'(bus.ram_write), 64'(1));
    chk("t1_addr_n4", 64'(bus.ram_addr),  64'(30'h40));
    bus.ram_ack = 1'b1;
    cyc();
    bus.ram_ack = 1'b0;
    chk("t1_wr_gap",   64'(bus.ram_write), 64'(0));
    chk("t1_busy_gap", 64'(busy),          64'(1));
    cyc();
    chk("t1_busy_end", 64'(busy), 64'(0));
    $display("single write done");

    // ---- 20 back-to-back writes; bridge silent until level hits 16 ----
    // Entry 0 is popped at once and times out; entry 1 is issued after it,
    // so 18 writes fit before the FIFO reports full.
    clear_log();
    ack_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (level == 5'd16) ack_en = 1'b1;
      bridge_step(ack_en);
      if (i > 0) chk("t2_ack", 64'(bus.mem_ack), 64'(i <= 18));
      chk("t2_stall", 64'(bus.mem_stall), 64'(i >= 18));
      if (i == 18) chk("t2_level_full", 64'(level), 64'(16));
      j = 32'(i);
      put(1'b1, 32'h0000_1000 + (j << 2), 32'hA500_0000 + j, j[3:0]);
    end
    cyc();
    idle_bus();
    bridge_step(1'b1);
    chk("t2_ack_stalled", 64'(bus.mem_ack), 64'(0));
    drain("t2");
    chk("t2_count", 64'(got_addr.size()), 64'(17));
    for (int k = 0; k < 17 && k < got_addr.size(); k++) begin
      j = 32'(k + 1);
      chk("t2_addr", 64'(got_addr[k]), 64'(32'h400 + j));
      chk("t2_data", 64'(got_data[k]), 64'(32'hA500_0000 + j));
      chk("t2_be",   64'(got_be[k]),   64'(j[3:0]));
    end
    chk("t2_err", 64'(err), 64'(1));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t2_err_clr", 64'(err), 64'(0));
    $display("burst done");

    // ---- read between two writes (second write has sel=0) ----
    clear_log();
    cyc();
    bridge_step(1'b1);
    put(1'b1, 32'h0000_0200, 32'h1111_1111, 4'h3);
    cyc();
    bridge_step(1'b1);
    chk("t3_ack_w0", 64'(bus.mem_ack), 64'(1));
    put(1'b0, 32'h0000_0300, 32'h3333_3333, 4'hF);
    cyc();
    bridge_step(1'b1);
    chk("t3_ack_rd", 64'(bus.mem_ack), 64'(1));
    put(1'b1, 32'h0000_0204, 32'h2222_2222, 4'h0);
    cyc();
    bridge_step(1'b1);
    chk("t3_ack_w1", 64'(bus.mem_ack), 64'(1));
    idle_bus();
    drain("t3");
    chk("t3_count", 64'(got_addr.size()), 64'(2));
    if (got_addr.size() >= 2) begin
      chk("t3_addr0", 64'(got_addr[0]), 64'(30'h80));
      chk("t3_data0", 64'(got_data[0]), 64'(32'h1111_1111));
      chk("t3_be0",   64'(got_be[0]),   64'(4'h3));
      chk("t3_addr1", 64'(got_addr[1]), 64'(30'h81));
      chk("t3_data1", 64'(got_data[1]), 64'(32'h2222_2222));
      chk("t3_be1",   64'(got_be[1]),   64'(4'h0));
    end
    $display("read interleave done");

    // ---- watchdog: bridge never acks ----
    chk("t4_err_pre", 64'(err), 64'(0));
    cyc();
    put(1'b1, 32'h0000_0400, 32'hAAAA_0000, 4'hF);
    cyc();
    put(1'b1, 32'h0000_0404, 32'hBBBB_0000, 4'hF);
    cyc();
    idle_bus();
    chk("t4_wr_a",   64'(bus.ram_write), 64'(1));
    chk("t4_addr_a", 64'(bus.ram_addr),  64'(30'h100));
    wcount = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.ram_write) wcount++;
      cyc();
    end
    chk("t4_hold_a",  64'(wcount),        64'(8));
    chk("t4_drop_a",  64'(bus.ram_write), 64'(0));
    chk("t4_err_set", 64'(err),           64'(1));
    bus.ram_ack = 1'b1;
    cyc();
    chk("t4_idle_wr",    64'(bus.ram_write), 64'(0));
    chk("t4_idle_level", 64'(level),         64'(1));
    cyc();
    bus.ram_ack = 1'b0;
    chk("t4_wr_b",   64'(bus.ram_write), 64'(1));
    chk("t4_addr_b", 64'(bus.ram_addr),  64'(30'h101));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_err_clr", 64'(err), 64'(0));
    wcount = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.ram_write) wcount++;
      cyc();
    end
    chk("t4_wr_b_last", 64'(bus.ram_write), 64'(1));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_hold_b",      64'(wcount),        64'(6));
    chk("t4_drop_b",      64'(bus.ram_write), 64'(0));
    chk("t4_set_over_clr", 64'(err),          64'(1));
    cyc();
    chk("t4_busy_end", 64'(busy), 64'(0));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_err_clr2", 64'(err), 64'(0));
    $display("watchdog done");

    // ---- asynchronous reset mid-write with 5 entries queued ----
    for (int i = 0; i < 6; i++) begin
      cyc();
      j = 32'(i);
      put(1'b1, 32'h0000_0800 + (j << 2), 32'hC0DE_0000 + j, 4'hF);
    end
    cyc();
    idle_bus();
    chk("t5_wr_pre",    64'(bus.ram_write), 64'(1));
    chk("t5_level_pre", 64'(level),         64'(5));
    chk("t5_ack_pre",   64'(bus.mem_ack),   64'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_write", 64'(bus.ram_write), 64'(0));
    chk("t5_rst_addr",  64'(bus.ram_addr),  64'(0));
    chk("t5_rst_data",  64'(bus.ram_data),  64'(0));
    chk("t5_rst_be",    64'(bus.ram_be),    64'(0));
    chk("t5_rst_ack",   64'(bus.mem_ack),   64'(0));
    chk("t5_rst_stall", 64'(bus.mem_stall), 64'(0));
    chk("t5_rst_level", 64'(level),         64'(0));
    chk("t5_rst_busy",  64'(busy),          64'(0));
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t5_post_level", 64'(level),         64'(0));
    chk("t5_post_busy",  64'(busy),          64'(0));
    cyc();
    cyc();
    chk("t5_post_write", 64'(bus.ram_write), 64'(0));
    $display("reset mid-write done");

    // ---- push and pop in the same cycle at level 3 ----
    clear_log();
    cyc();
    put(1'b1, 32'h0000_0A00, 32'h6000_0000, 4'hF);
    cyc();
    put(1'b1, 32'h0000_0A04, 32'h6000_0001, 4'hF);
    cyc();
    put(1'b1, 32'h0000_0A08, 32'h6000_0002, 4'hF);
    chk("t6_wr_e0", 64'(bus.ram_write), 64'(1));
    cyc();
    put(1'b1, 32'h0000_0A0C, 32'h6000_0003, 4'hF);
    bus.ram_ack = 1'b1;
    cyc();
    idle_bus();
    bus.ram_ack = 1'b0;
    chk("t6_level_gap", 64'(level),         64'(3));
    chk("t6_wr_gap",    64'(bus.ram_write), 64'(0));
    cyc();
    put(1'b1, 32'h0000_0A10, 32'h6000_0004, 4'hF);
    chk("t6_level_idle", 64'(level),         64'(3));
    chk("t6_wr_idle",    64'(bus.ram_write), 64'(0));
    cyc();
    idle_bus();
    chk("t6_level_pp", 64'(level),         64'(3));
    chk("t6_wr_e1",    64'(bus.ram_write), 64'(1));
    chk("t6_addr_e1",  64'(bus.ram_addr),  64'(30'h281));
    drain("t6");
    chk("t6_count", 64'(got_addr.size()), 64'(4));
    for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
      j = 32'(k + 1);
      chk("t6_addr", 64'(got_addr[k]), 64'(32'h280 + j));
      chk("t6_data", 64'(got_data[k]), 64'(32'h6000_0000 + j));
    end
    chk("t6_err", 64'(err), 64'(0));
    $display("push/pop same cycle done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
